hatch_countdown: RTL and testbench

- Countdown timer for the egg-hatch design, complementing the up-counting elapsed-seconds counter.
- Loads a preset number of seconds and counts down to zero on an internal seconds tick derived from clk.
- Supports pause and resume.
- On expiry, emits a one-cycle done pulse and holds an alarm level until it is acknowledged.
- Sits between the preset/key logic and the display/buzzer logic.

---
 rtl/hatch_pkg.sv | 19 +
 rtl/hatch_countdown_sec_prescaler.sv | 31 +++
 rtl/hatch_countdown.sv | 111 +++++++++++
 tb/tb_hatch_countdown.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hatch_pkg.sv
// Shared definitions for the egg-hatch countdown timer: state encoding and default sizing.
package hatch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int DEF_TICK_DIV = 1000;
  localparam int DEF_CNT_W    = 5;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_PAUSE = ST_PAUSE,
    S_DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/hatch_countdown_sec_prescaler.sv
// Seconds prescaler: counts clk cycles while enabled and flags the last cycle of each second.
module sec_prescaler
  import hatch_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int QW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [QW-1:0] q;

  assign tick = en && (q == QW'(TICK_DIV - 1));

  // q holds while disabled so a pause keeps the partial second
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= tick ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/hatch_countdown.sv
// Countdown timer with pause/resume, expiry pulse and held alarm.
// Optional near-expiry warning output enabled by defining HATCH_WARN_EN.
module hatch_countdown
  import hatch_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int WARN_TH  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] preset,
  input  logic             st,
  input  logic             ack,
  output logic [CNT_W-1:0] remain,
  output logic             busy,
  output logic             done,
  output logic             alarm,
  output logic             warn
);

  state_t           state, state_n;
  logic [CNT_W-1:0] remain_n;
  logic             done_n, alarm_n, busy_n;
  logic             tick;

  sec_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   ((state == S_RUN) && !load),
    .clr  (load),
    .tick (tick)
  );

  // Next-state logic; load overrides everything, including a coincident tick
  always_comb begin
    state_n  = state;
    remain_n = remain;
    done_n   = 1'b0;
    alarm_n  = alarm;
    if (load) begin
      remain_n = preset;
      alarm_n  = 1'b0;
      if (preset == '0)
        state_n = S_IDLE;
      else
        state_n = st ? S_RUN : S_PAUSE;
    end else begin
      case (state)
        S_RUN: begin
          if (tick) begin
            if (remain > CNT_W'(1)) begin
              remain_n = remain - 1'b1;
            end else begin
              remain_n = '0;
              state_n  = S_DONE;
              done_n   = 1'b1;
              alarm_n  = 1'b1;
            end
          end
          if (!st && state_n == S_RUN)
            state_n = S_PAUSE;
        end
        S_PAUSE: begin
          if (st)
            state_n = S_RUN;
        end
        S_DONE: begin
          remain_n = '0;
          alarm_n  = 1'b1;
          if (ack) begin
            state_n = S_IDLE;
            alarm_n = 1'b0;
          end
        end
        default: ;
      endcase
    end
    busy_n = (state_n == S_RUN) || (state_n == S_PAUSE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      remain <= '0;
      done   <= 1'b0;
      alarm  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      remain <= remain_n;
      done   <= done_n;
      alarm  <= alarm_n;
      busy   <= busy_n;
    end
  end

`ifdef HATCH_WARN_EN
  // Evaluated on next-state values so warn moves on the same edge as remain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      warn <= 1'b0;
    else
      warn <= busy_n && (remain_n <= CNT_W'(WARN_TH)) && (remain_n != '0);
  end
`else
  assign warn = (WARN_TH < 0);
`endif

endmodule

// File: tb/tb_hatch_countdown.sv
// Directed bench for hatch_countdown with TICK_DIV=4, CNT_W=5, WARN_TH=3.
module tb_hatch_countdown;

  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 5;
  localparam int WARN_TH  = 3;
`ifdef HATCH_WARN_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             load;
  logic [CNT_W-1:0] preset;
  logic             st;
  logic             ack;
  logic [CNT_W-1:0] remain;
  logic             busy, done, alarm, warn;

  int checks = 0;
  int errors = 0;

  hatch_countdown #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W), .WARN_TH(WARN_TH)) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .preset (preset),
    .st     (st),
    .ack    (ack),
    .remain (remain),
    .busy   (busy),
    .done   (done),
    .alarm  (alarm),
    .warn   (warn)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic l, input logic [CNT_W-1:0] p, input logic s, input logic a);
    load   = l;
    preset = p;
    st     = s;
    ack    = a;
  endtask

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkAll(input string tag, input logic [CNT_W-1:0] r, input logic b,
                          input logic d, input logic al, input logic w);
    checkOutput({tag, ".remain"}, 32'(remain), 32'(r));
    checkOutput({tag, ".busy"},   32'(busy),   32'(b));
    checkOutput({tag, ".done"},   32'(done),   32'(d));
    checkOutput({tag, ".alarm"},  32'(alarm),  32'(al));
    checkOutput({tag, ".warn"},   32'(warn),   32'(w & WEN));
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    #3;
    checkAll("reset", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(2);
    checkAll("idle", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] basic countdown from 3");
    applyStimulus(1'b1, 5'd3, 1'b1, 1'b0);
    step(1);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0);
    checkAll("ld3.e0", 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    step(3);
    checkAll("ld3.e3", 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1);
    checkAll("ld3.e4", 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4);
    checkAll("ld3.e8", 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(3);
    checkAll("ld3.e11", 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1);
    checkAll("ld3.e12", 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1);
    checkAll("ld3.e13", 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 1'b0, 1'b0);
    step(3);
    checkAll("done.st_ignored", 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b1);
    step(1);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0);
    checkAll("ack", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(5);
    checkAll("idle.st_ignored", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] pause and resume");
    applyStimulus(1'b1, 5'd5, 1'b1, 1'b0);
    step(1);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0);
    checkAll("p.e0", 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4);
    checkAll("p.e4", 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    st = 1'b0;
    step(1);
    checkAll("p.e6", 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(19);
    checkAll("p.e25", 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    st = 1'b1;
    step(2);
    checkAll("p.e27", 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    checkAll("p.e28", 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4);
    checkAll("p.e32", 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4);
    checkAll("p.e36", 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(3);
    checkAll("p.e39", 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1);
    checkAll("p.e40", 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("[TB] load while in DONE");
    applyStimulus(1'b1, 5'd2, 1'b1, 1'b0);
    step(1);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0);
    checkAll("ldd.e0", 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4);
    checkAll("ldd.e4", 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4);
    checkAll("ldd.e8", 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("[TB] load and ack together");
    applyStimulus(1'b1, 5'd6, 1'b1, 1'b1);
    step(1);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0);
    checkAll("ldack", 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] load on a tick cycle");
    step(3);
    checkAll("ldtick.pre", 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd9, 1'b1, 1'b0);
    step(1);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0);
    checkAll("ldtick.e0", 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    step(3);
    checkAll("ldtick.e3", 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    checkAll("ldtick.e4", 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] load zero preset");
    applyStimulus(1'b1, 5'd0, 1'b1, 1'b0);
    step(1);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0);
    checkAll("ld0.e0", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(10);
    checkAll("ld0.e10", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] st falling on a tick cycle");
    applyStimulus(1'b1, 5'd5, 1'b1, 1'b0);
    step(1);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0);
    step(3);
    st = 1'b0;
    step(1);
    checkAll("stfall.e4", 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8);
    checkAll("stfall.hold", 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] async reset mid-run");
    applyStimulus(1'b1, 5'd7, 1'b1, 1'b0);
    step(1);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0);
    step(2);
    checkAll("ar.pre", 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkAll("ar.async", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    #2;
    rst = 1'b1;
    step(6);
    checkAll("ar.after", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
